// File: rtl/dc_pred_accum.sv
// dc_pred_accum: sums available left/top neighbour samples and registers the rounded DC predictor.
module dc_pred_accum #(
  parameter int BIT_DEPTH = 8
) (
  input  logic                 CLK_HIGH,
  input  logic                 RST_n,
  input  logic                 preset_flag,
  input  logic                 EN_LEFT,
  input  logic                 EN_TOP,
  input  logic                 LEFT_AVAIL,
  input  logic                 TOP_AVAIL,
  input  logic [BIT_DEPTH-1:0] DIN,
  output logic [BIT_DEPTH-1:0] DC_VAL,
  output logic                 DC_VALID,
  output logic                 BUSY
);
  localparam int W = BIT_DEPTH + 3;
  typedef enum logic [2:0] {IDLE, WAIT, LEFT, TOP, DONE} state_t;
  state_t               state;
  logic [1:0]           cnt;
  logic [BIT_DEPTH+1:0] sum_left, sum_top;
  logic                 left_ok, top_ok, en_left_d, en_top_d;
  logic [BIT_DEPTH-1:0] dc;
  always_comb begin
    dc = left_ok && top_ok ? BIT_DEPTH'(({1'b0, sum_left} + {1'b0, sum_top} + W'(4)) >> 3)
       : left_ok           ? BIT_DEPTH'((sum_left + (BIT_DEPTH+2)'(2)) >> 2)
       : top_ok            ? BIT_DEPTH'((sum_top + (BIT_DEPTH+2)'(2)) >> 2)
       :                     {1'b1, {(BIT_DEPTH-1){1'b0}}};
  end
  // preset_flag is applied last so it overrides any phase, including DONE
  always_ff @(posedge CLK_HIGH or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sum_left  <= '0;
      sum_top   <= '0;
      left_ok   <= 1'b0;
      top_ok    <= 1'b0;
      en_left_d <= 1'b0;
      en_top_d  <= 1'b0;
      DC_VAL    <= '0;
      DC_VALID  <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      en_left_d <= EN_LEFT;
      en_top_d  <= EN_TOP;
      DC_VALID  <= 1'b0;
      case (state)
        WAIT: begin
          state <= LEFT;
          cnt   <= '0;
        end
        LEFT: begin
          if (en_left_d && left_ok) sum_left <= sum_left + {2'b0, DIN};
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= TOP;
        end
        TOP: begin
          if (en_top_d && top_ok) sum_top <= sum_top + {2'b0, DIN};
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= DONE;
        end
        DONE: begin
          DC_VAL   <= dc;
          DC_VALID <= 1'b1;
          BUSY     <= 1'b0;
          state    <= IDLE;
        end
        default: ;
      endcase
      if (preset_flag) begin
        state    <= WAIT;
        cnt      <= '0;
        sum_left <= '0;
        sum_top  <= '0;
        left_ok  <= LEFT_AVAIL;
        top_ok   <= TOP_AVAIL;
        BUSY     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dc_pred_accum.sv
// tb_dc_pred_accum: directed checks of DC predictor value, timing, restart and reset behaviour.
module tb_dc_pred_accum;
  logic       CLK_HIGH = 1'b0, RST_n = 1'b0;
  logic       preset_flag = 1'b0, EN_LEFT = 1'b0, EN_TOP = 1'b0;
  logic       LEFT_AVAIL = 1'b0, TOP_AVAIL = 1'b0;
  logic [7:0] DIN = '0, DC_VAL;
  logic       DC_VALID, BUSY;
  int checks = 0, errors = 0;
  int lv[4], tv[4];

  dc_pred_accum #(.BIT_DEPTH(8)) dut (
    .CLK_HIGH(CLK_HIGH), .RST_n(RST_n), .preset_flag(preset_flag),
    .EN_LEFT(EN_LEFT), .EN_TOP(EN_TOP), .LEFT_AVAIL(LEFT_AVAIL), .TOP_AVAIL(TOP_AVAIL),
    .DIN(DIN), .DC_VAL(DC_VAL), .DC_VALID(DC_VALID), .BUSY(BUSY));

  always #5 CLK_HIGH = ~CLK_HIGH;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive the inputs that are sampled at edge k of a block (edge 0 = preset edge)
  task automatic drive(input int k, input logic pf);
    preset_flag = pf;
    EN_LEFT = (k >= 1 && k <= 4);
    EN_TOP  = (k >= 5);
    DIN = (k >= 2 && k <= 5) ? 8'(lv[k-2]) : (k >= 6 && k <= 9) ? 8'(tv[k-6]) : 8'd200;
    @(posedge CLK_HIGH);
    #1;
  endtask

  task automatic run_from(input int k0, input int held);
    for (int k = k0; k <= 9; k++) begin
      drive(k, k == 0);
      chk("busy_run", BUSY, 1);
      chk("valid_run", DC_VALID, 0);
      chk("val_held", DC_VAL, held);
    end
  endtask

  task automatic finish(input int exp, input logic pf);
    drive(10, pf);
    chk("valid_done", DC_VALID, 1);
    chk("dc_val", DC_VAL, exp);
    chk("busy_done", BUSY, int'(pf));
  endtask

  task automatic idle_after(input int exp);
    drive(11, 1'b0);
    chk("valid_pulse_end", DC_VALID, 0);
    chk("val_hold", DC_VAL, exp);
  endtask

  initial begin
    #12;
    chk("rst_val", DC_VAL, 0);
    chk("rst_valid", DC_VALID, 0);
    chk("rst_busy", BUSY, 0);
    RST_n = 1'b1;
    drive(20, 1'b0);
    // both available: (360+4)>>3 = 45
    lv = '{10, 20, 30, 40}; tv = '{50, 60, 70, 80};
    LEFT_AVAIL = 1; TOP_AVAIL = 1;
    run_from(0, 0); finish(45, 0); idle_after(45);
    // left only: (7+2)>>2 = 2
    lv = '{1, 2, 2, 2}; tv = '{255, 255, 255, 255};
    LEFT_AVAIL = 1; TOP_AVAIL = 0;
    run_from(0, 45); finish(2, 0); idle_after(2);
    // top only, with the next block started in the DONE cycle: (1020+2)>>2 = 255
    LEFT_AVAIL = 0; TOP_AVAIL = 1;
    run_from(0, 2);
    LEFT_AVAIL = 0; TOP_AVAIL = 0;
    finish(255, 1);
    // neither available: 128
    lv = '{7, 9, 11, 13}; tv = '{1, 2, 3, 4};
    run_from(1, 255); finish(128, 0); idle_after(128);
    // restart at edge 4: first block aborted, second (400+4)>>3 = 50
    lv = '{1, 1, 1, 1}; tv = '{1, 1, 1, 1};
    LEFT_AVAIL = 1; TOP_AVAIL = 1;
    for (int k = 0; k <= 3; k++) drive(k, k == 0);
    lv = '{100, 100, 100, 100}; tv = '{0, 0, 0, 0};
    run_from(0, 128); finish(50, 0); idle_after(50);
    // asynchronous reset in mid-block
    lv = '{8, 8, 8, 8}; tv = '{8, 8, 8, 8};
    for (int k = 0; k <= 5; k++) drive(k, k == 0);
    #2 RST_n = 1'b0;
    #1;
    chk("arst_val", DC_VAL, 0);
    chk("arst_valid", DC_VALID, 0);
    chk("arst_busy", BUSY, 0);
    drive(6, 1'b0);
    RST_n = 1'b1;
    for (int k = 7; k <= 18; k++) begin
      drive(k, 1'b0);
      chk("post_rst_valid", DC_VALID, 0);
      chk("post_rst_busy", BUSY, 0);
    end
    // block after reset: (24+56+4)>>3 = 10
    lv = '{3, 5, 7, 9}; tv = '{11, 13, 15, 17};
    run_from(0, 0); finish(10, 0); idle_after(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
